// File: rtl/mac_array_acc.sv
// mac_array_acc: DIM_C x DIM_A multiply-accumulate array with valid/ready handshake, signed mode and saturation
module mac_array_acc #(
  parameter int DIM_A = 4,
  parameter int DIM_C = 4,
  parameter int INPUT_WIDTH = 4,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH = 16,
  parameter int LEN_WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DIM_A*INPUT_WIDTH-1:0]       in,
  input  logic [DIM_C*WEIGHT_WIDTH-1:0]      weight,
  input  logic [LEN_WIDTH-1:0]               acc_len,
  input  logic                               signed_mode,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DIM_C*DIM_A*ACC_WIDTH-1:0]   out,
  output logic                               sat_flag
);
  localparam int PW = INPUT_WIDTH + WEIGHT_WIDTH;
  localparam int AW1 = ACC_WIDTH + 1;
  localparam int SW = ACC_WIDTH + 2;
  localparam int N = DIM_C * DIM_A;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [LEN_WIDTH-1:0] len_q, cnt, len_eff;
  logic mode_q, stall, accept, first, last, mode;
  logic s1_valid, s1_first, s1_last, s1_mode;
  logic [DIM_A*INPUT_WIDTH-1:0] s1_in;
  logic [DIM_C*WEIGHT_WIDTH-1:0] s1_w;
  logic s2_valid, s2_first, s2_last, s2_mode;
  logic [N*AW1-1:0] prod, s2_prod;
  logic s3_valid, s3_last, s3_sat;
  logic [N*ACC_WIDTH-1:0] acc, acc_nxt;
  logic [N-1:0] clamp;

  assign stall = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept = in_valid & in_ready;
  assign first = state == IDLE;
  assign len_eff = acc_len == '0 ? LEN_WIDTH'(1) : acc_len;
  assign last = first ? len_eff == LEN_WIDTH'(1) : cnt == len_q - LEN_WIDTH'(1);
  assign mode = first ? signed_mode : mode_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      len_q <= '0;
      mode_q <= 1'b0;
    end else if (accept) begin
      if (first) begin
        len_q <= len_eff;
        mode_q <= signed_mode;
      end
      state <= last ? IDLE : RUN;
      cnt <= last ? '0 : cnt + LEN_WIDTH'(1);
    end
  end

  for (genvar c = 0; c < DIM_C; c++) begin : g_c
    for (genvar a = 0; a < DIM_A; a++) begin : g_a
      logic [PW-1:0] x, w, p;
      logic signed [SW-1:0] pe, ae, sum, hi, lo;
      assign x = {{(PW-INPUT_WIDTH){s1_mode & s1_in[a*INPUT_WIDTH+INPUT_WIDTH-1]}}, s1_in[a*INPUT_WIDTH +: INPUT_WIDTH]};
      assign w = {{(PW-WEIGHT_WIDTH){s1_mode & s1_w[c*WEIGHT_WIDTH+WEIGHT_WIDTH-1]}}, s1_w[c*WEIGHT_WIDTH +: WEIGHT_WIDTH]};
      assign p = x * w;
      assign prod[(c*DIM_A+a)*AW1 +: AW1] = {{(AW1-PW){s1_mode & p[PW-1]}}, p};
      assign pe = {s2_mode & s2_prod[(c*DIM_A+a)*AW1+AW1-1], s2_prod[(c*DIM_A+a)*AW1 +: AW1]};
      assign ae = {{2{s2_mode & acc[(c*DIM_A+a)*ACC_WIDTH+ACC_WIDTH-1]}}, acc[(c*DIM_A+a)*ACC_WIDTH +: ACC_WIDTH]};
      assign sum = s2_first ? pe : ae + pe;
      assign hi = {2'b00, ~s2_mode, {(ACC_WIDTH-1){1'b1}}};
      assign lo = {{3{s2_mode}}, {(ACC_WIDTH-1){1'b0}}};
      assign clamp[c*DIM_A+a] = sum > hi || sum < lo;
      assign acc_nxt[(c*DIM_A+a)*ACC_WIDTH +: ACC_WIDTH] = sum > hi ? hi[ACC_WIDTH-1:0] : sum < lo ? lo[ACC_WIDTH-1:0] : sum[ACC_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      s3_sat <= 1'b0;
      out_valid <= 1'b0;
      out <= '0;
      sat_flag <= 1'b0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) {s1_in, s1_w, s1_first, s1_last, s1_mode} <= {in, weight, first, last, mode};
      s2_valid <= s1_valid;
      if (s1_valid) {s2_prod, s2_first, s2_last, s2_mode} <= {prod, s1_first, s1_last, s1_mode};
      s3_valid <= s2_valid;
      if (s2_valid) begin
        acc <= acc_nxt;
        s3_last <= s2_last;
        s3_sat <= (~s2_first & s3_sat) | (|clamp);
      end
      out_valid <= s3_valid & s3_last;
      if (s3_valid & s3_last) begin
        out <= acc;
        sat_flag <= s3_sat;
      end
    end
  end
endmodule

// File: tb/tb_mac_array_acc.sv
// tb_mac_array_acc: table, directed and randomized checks of mac_array_acc against a group-level model
module tb_mac_array_acc;
  typedef struct {logic [255:0] out; bit sat;} exp_t;
  typedef struct {logic [3:0] i; logic [7:0] w; logic [7:0] len; bit md; logic [15:0] e; bit s;} vec_t;
  logic clk = 0, rst_n = 0, in_valid = 0, signed_mode = 0, in_ready, out_valid, out_ready, sat_flag;
  logic [15:0] din = 0;
  logic [31:0] wt = 0;
  logic [7:0] acc_len = 0;
  logic [255:0] dout;
  int errors = 0, checks = 0, rdy_mode = 0;
  exp_t expq[$];
  logic [15:0] gin[$];
  logic [31:0] gw[$];
  vec_t tbl[7];

  mac_array_acc dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in(din), .weight(wt),
    .acc_len(acc_len), .signed_mode(signed_mode), .out_valid(out_valid), .out_ready(out_ready),
    .out(dout), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  initial begin
    out_ready = 1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rdy_mode == 2 ? ($urandom_range(0, 3) != 0) : rdy_mode == 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int el(input logic [31:0] v, input int idx, input int w, input bit md);
    int u;
    u = int'((v >> (idx * w)) & ((32'd1 << w) - 1));
    return (md && u >= (1 << (w - 1))) ? u - (1 << w) : u;
  endfunction

  function automatic exp_t model(input bit md, input int n);
    exp_t e;
    longint hi, lo, s;
    e.out = '0;
    e.sat = 0;
    hi = md ? 32767 : 65535;
    lo = md ? -32768 : 0;
    for (int c = 0; c < 4; c++)
      for (int a = 0; a < 4; a++) begin
        s = 0;
        for (int b = 0; b < n; b++) begin
          s += longint'(el(gin[b], a, 4, md)) * el(gw[b], c, 8, md);
          if (s > hi) begin s = hi; e.sat = 1; end
          if (s < lo) begin s = lo; e.sat = 1; end
        end
        e.out[(c*4+a)*16 +: 16] = s[15:0];
      end
    return e;
  endfunction

  function automatic exp_t uni(input logic [15:0] v, input bit s);
    exp_t e;
    e.out = {16{v}};
    e.sat = s;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected out_valid: out=%0h sat=%0d", dout, sat_flag);
      end else begin
        chk(out_ready ? "result out" : "held out", dout, expq[0].out);
        chk(out_ready ? "result sat" : "held sat", sat_flag, expq[0].sat);
        if (out_ready) void'(expq.pop_front());
      end
    end
  end

  task automatic drive_beat(input logic [15:0] iv, input logic [31:0] wv, input logic [7:0] len, input bit md);
    bit rdy;
    int t;
    din = iv;
    wt = wv;
    acc_len = len;
    signed_mode = md;
    in_valid = 1;
    t = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!rdy && t < 500);
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL accept timeout: in_ready=%0d required 1", rdy);
    end
    in_valid = 0;
  endtask

  task automatic send_group(input int len, input bit md, input bit gaps, input bit use_exp, input exp_t ex);
    int n;
    n = len == 0 ? 1 : len;
    if (use_exp) expq.push_back(ex);
    else expq.push_back(model(md, n));
    for (int b = 0; b < n; b++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      if (b == 0) drive_beat(gin[b], gw[b], 8'(len), md);
      else drive_beat(gin[b], gw[b], 8'($urandom), 1'($urandom));
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (expq.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain", expq.size(), 0);
  endtask

  initial begin
    exp_t e;
    int len, n;
    bit md;
    tbl[0] = '{4'd3, 8'd5, 8'd1, 1'b0, 16'd15, 1'b0};
    tbl[1] = '{4'h8, 8'h7f, 8'd1, 1'b1, 16'hfc08, 1'b0};
    tbl[2] = '{4'hf, 8'hff, 8'd0, 1'b0, 16'h0ef1, 1'b0};
    tbl[3] = '{4'hf, 8'hff, 8'd1, 1'b1, 16'h0001, 1'b0};
    tbl[4] = '{4'h7, 8'h80, 8'd1, 1'b1, 16'hfc80, 1'b0};
    tbl[5] = '{4'h7, 8'h80, 8'd0, 1'b0, 16'h0380, 1'b0};
    tbl[6] = '{4'h0, 8'hff, 8'd1, 1'b1, 16'h0000, 1'b0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset out", dout, 0);
    chk("reset sat_flag", sat_flag, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    @(negedge clk);
    chk("in_ready after reset", in_ready, 1);
    @(posedge clk);
    #1;

    expq.push_back(uni(16'd15, 1'b0));
    drive_beat({4{4'd3}}, {4{8'd5}}, 8'd1, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("latency early", out_valid, 0);
    end
    @(negedge clk);
    chk("latency t+3", out_valid, 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      gin = '{{4{tbl[i].i}}};
      gw = '{{4{tbl[i].w}}};
      send_group(int'(tbl[i].len), tbl[i].md, 1'b0, 1'b1, uni(tbl[i].e, tbl[i].s));
    end
    drain();

    gin = '{16'h4321, 16'h4321, 16'h4321, 16'h4321};
    gw = '{32'h04030201, 32'h04030201, 32'h04030201, 32'h04030201};
    e.sat = 0;
    e.out = '0;
    for (int c = 0; c < 4; c++)
      for (int a = 0; a < 4; a++) e.out[(c*4+a)*16 +: 16] = 16'(4 * (a + 1) * (c + 1));
    send_group(4, 1'b0, 1'b0, 1'b1, e);
    drain();

    gin = '{16'h8888, 16'h8888};
    gw = '{32'h7f7f7f7f, 32'h80808080};
    send_group(2, 1'b1, 1'b0, 1'b1, uni(16'd8, 1'b0));
    gin = '{16'hffff, 16'hffff};
    gw = '{32'hffffffff, 32'hffffffff};
    send_group(2, 1'b0, 1'b0, 1'b1, uni(16'd7650, 1'b0));
    drain();

    gin.delete();
    gw.delete();
    for (int b = 0; b < 255; b++) begin
      gin.push_back(16'hffff);
      gw.push_back(32'hffffffff);
    end
    send_group(255, 1'b0, 1'b0, 1'b1, uni(16'hffff, 1'b1));
    gin.delete();
    gw.delete();
    for (int b = 0; b < 40; b++) begin
      gin.push_back(16'h8888);
      gw.push_back(32'h7f7f7f7f);
    end
    send_group(40, 1'b1, 1'b1, 1'b1, uni(16'h8000, 1'b1));
    drain();

    rdy_mode = 1;
    @(posedge clk);
    #1;
    gin = '{16'h1111};
    gw = '{32'h01010101};
    send_group(1, 1'b0, 1'b0, 1'b1, uni(16'd1, 1'b0));
    gin = '{16'h2222};
    gw = '{32'h03030303};
    send_group(1, 1'b0, 1'b0, 1'b1, uni(16'd6, 1'b0));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    repeat (5) begin
      chk("stall in_ready", in_ready, 0);
      chk("stall out_valid", out_valid, 1);
      @(negedge clk);
    end
    rdy_mode = 0;
    @(posedge clk);
    #1;
    drain();

    drive_beat(16'h1111, 32'h01010101, 8'd4, 1'b0);
    drive_beat(16'h1111, 32'h01010101, 8'd4, 1'b0);
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    @(negedge clk);
    chk("mid reset out_valid", out_valid, 0);
    chk("mid reset in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    gin = '{16'h2222};
    gw = '{32'h09090909};
    send_group(1, 1'b0, 1'b0, 1'b1, uni(16'd18, 1'b0));
    drain();

    rdy_mode = 2;
    repeat (40) begin
      len = $urandom_range(0, 7) == 0 ? $urandom_range(10, 30) : $urandom_range(0, 5);
      md = 1'($urandom);
      n = len == 0 ? 1 : len;
      gin.delete();
      gw.delete();
      for (int b = 0; b < n; b++) begin
        gin.push_back(16'($urandom));
        gw.push_back($urandom);
      end
      send_group(len, md, 1'b1, 1'b0, uni(16'd0, 1'b0));
    end
    rdy_mode = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
